// File: rtl/tekbot_motor_drive.sv
// tekbot_motor_drive
//   Drives the two TekBot H-bridges from the bumper/steering stage's
//   per-side enable/direction requests. Each side gets a PWM enable at a
//   shared programmable duty, and any direction reversal while running is
//   preceded by a dead-time with the bridge disabled.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   Len/Ldir          left enable/direction request (asynchronous)
//   Ren/Rdir          right enable/direction request (asynchronous)
//   duty[PWM_BITS]    PWM duty, synchronous to clk, sampled once per period
//   L_pwm/R_pwm       bridge enable (PWM)
//   L_dir/R_dir       bridge direction
//   L_busy/R_busy     side is in reversal dead-time
//
// Parameters
//   PWM_BITS  counter/duty width; PWM period is 2^PWM_BITS clocks
//   DEADTIME  clocks of forced-low PWM ahead of a direction change (1..255)

// ---------------------------------------------------------------------------
// One bridge side: command synchronizer, STOP/RUN/DEAD FSM, output flops.
// ---------------------------------------------------------------------------
module tekbot_motor_side #(
  parameter int DEADTIME = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en_async,
  input  logic dir_async,
  input  logic pwm_raw_nxt,   // PWM level for the cycle after this edge
  output logic pwm,
  output logic dir,
  output logic busy
);
  localparam int TW = 8;

  typedef enum logic [1:0] {STOP, RUN, DEAD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    en_sync, dir_sync;
  logic          en_s, dir_s;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          dir_d, pwm_d, busy_d;

  // two-flop synchronizers; bit 1 is the usable, synchronized value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_sync  <= '0;
      dir_sync <= '0;
    end else begin
      en_sync  <= {en_sync[0], en_async};
      dir_sync <= {dir_sync[0], dir_async};
    end
  end

  assign en_s  = en_sync[1];
  assign dir_s = dir_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STOP;
      tmr_q   <= '0;
      dir     <= 1'b0;
      pwm     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dir     <= dir_d;
      pwm     <= pwm_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dir_d   = dir;
    case (state_q)
      // bridge is off, so the direction can simply track the request
      STOP: begin
        dir_d = dir_s;
        if (en_s) state_d = RUN;
      end
      // dropping enable takes priority over a reversal; the direction
      // then catches up for free in STOP
      RUN: begin
        if (!en_s) begin
          state_d = STOP;
        end else if (dir_s != dir) begin
          state_d = DEAD;
          tmr_d   = TW'(DEADTIME - 1);
        end
      end
      // always runs to completion regardless of what the requests do,
      // then picks up whatever direction/enable is current at that moment
      DEAD: begin
        if (tmr_q == '0) begin
          dir_d   = dir_s;
          state_d = en_s ? RUN : STOP;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = STOP;
    endcase
    // outputs are registered from next-state values so they line up with
    // the state register rather than trailing it by a clock
    pwm_d  = (state_d == RUN) && pwm_raw_nxt;
    busy_d = (state_d == DEAD);
  end
endmodule

// ---------------------------------------------------------------------------
// Top: shared PWM timebase plus one side instance per motor.
// ---------------------------------------------------------------------------
module tekbot_motor_drive #(
  parameter int PWM_BITS = 8,
  parameter int DEADTIME = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Len,
  input  logic                Ldir,
  input  logic                Ren,
  input  logic                Rdir,
  input  logic [PWM_BITS-1:0] duty,
  output logic                L_pwm,
  output logic                L_dir,
  output logic                R_pwm,
  output logic                R_dir,
  output logic                L_busy,
  output logic                R_busy
);
  localparam int NUM_SIDES = 2;   // index 0 = left, 1 = right

  logic [PWM_BITS-1:0]  cnt, cnt_nxt, duty_q, duty_q_nxt;
  logic                 pwm_raw_nxt;
  logic [NUM_SIDES-1:0] en_a, dir_a, pwm_o, dir_o, busy_o;

  // duty is only sampled at the wrap so a period is never cut short
  assign cnt_nxt     = cnt + PWM_BITS'(1);
  assign duty_q_nxt  = (cnt == '1) ? duty : duty_q;
  // all-ones duty means fully on, not "on for all but the last count"
  assign pwm_raw_nxt = (duty_q_nxt == '1) || (cnt_nxt < duty_q_nxt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      duty_q <= '0;
    end else begin
      cnt    <= cnt_nxt;
      duty_q <= duty_q_nxt;
    end
  end

  assign en_a  = {Ren, Len};
  assign dir_a = {Rdir, Ldir};

  for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
    tekbot_motor_side #(.DEADTIME(DEADTIME)) u_side (
      .clk         (clk),
      .reset       (reset),
      .en_async    (en_a[s]),
      .dir_async   (dir_a[s]),
      .pwm_raw_nxt (pwm_raw_nxt),
      .pwm         (pwm_o[s]),
      .dir         (dir_o[s]),
      .busy        (busy_o[s])
    );
  end

  assign L_pwm  = pwm_o[0];
  assign L_dir  = dir_o[0];
  assign L_busy = busy_o[0];
  assign R_pwm  = pwm_o[1];
  assign R_dir  = dir_o[1];
  assign R_busy = busy_o[1];
endmodule

// File: tb/tb_tekbot_motor_drive.sv
// Bench for tekbot_motor_drive: directed scenarios plus random commands,
// with every output compared each cycle against a behavioural model.
module tb_tekbot_motor_drive;
  localparam int PB = 8;
  localparam int DT = 16;
  localparam int P  = 256;

  logic clk = 0, reset = 0;
  logic Len = 0, Ldir = 0, Ren = 0, Rdir = 0;
  logic [PB-1:0] duty = '0;
  logic L_pwm, L_dir, R_pwm, R_dir, L_busy, R_busy;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  tekbot_motor_drive #(.PWM_BITS(PB), .DEADTIME(DT)) dut (
    .clk(clk), .reset(reset),
    .Len(Len), .Ldir(Ldir), .Ren(Ren), .Rdir(Rdir), .duty(duty),
    .L_pwm(L_pwm), .L_dir(L_dir), .R_pwm(R_pwm), .R_dir(R_dir),
    .L_busy(L_busy), .R_busy(R_busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // edges = clocks since reset release, so the PWM count is edges mod P.
  // Each side: requests seen through a 2-deep delay, a running flag, and a
  // count of remaining dead clocks.
  int   edges = 0;
  int   dq = 0;
  bit   req_en[2][2], req_dir[2][2];
  bit   m_run[2], m_dir[2];
  int   m_dead[2];
  bit   e_pwm[2], e_dir[2], e_busy[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edges = 0;
      dq = 0;
      for (int s = 0; s < 2; s++) begin
        req_en[s][0] = 0; req_en[s][1] = 0;
        req_dir[s][0] = 0; req_dir[s][1] = 0;
        m_run[s] = 0; m_dir[s] = 0; m_dead[s] = 0;
        e_pwm[s] = 0; e_dir[s] = 0; e_busy[s] = 0;
      end
    end else begin
      bit raw, en_s, dir_s;
      bit in_en[2], in_dir[2];
      in_en[0] = Len; in_en[1] = Ren; in_dir[0] = Ldir; in_dir[1] = Rdir;
      if (edges % P == P - 1) dq = int'(duty);
      edges++;
      raw = (dq == P - 1) || ((edges % P) < dq);
      for (int s = 0; s < 2; s++) begin
        en_s  = req_en[s][1];
        dir_s = req_dir[s][1];
        req_en[s][1]  = req_en[s][0];  req_en[s][0]  = in_en[s];
        req_dir[s][1] = req_dir[s][0]; req_dir[s][0] = in_dir[s];
        if (m_dead[s] > 0) begin
          m_dead[s]--;
          if (m_dead[s] == 0) begin
            m_dir[s] = dir_s;
            m_run[s] = en_s;
          end
        end else if (!m_run[s]) begin
          m_dir[s] = dir_s;
          m_run[s] = en_s;
        end else if (!en_s) begin
          m_run[s] = 0;
        end else if (dir_s != m_dir[s]) begin
          m_dead[s] = DT;
        end
        e_pwm[s]  = m_run[s] && (m_dead[s] == 0) && raw;
        e_dir[s]  = m_dir[s];
        e_busy[s] = (m_dead[s] > 0);
      end
    end
  end

  // ---------------- per-cycle compare + invariants ----------------
  logic p_lpwm = 0, p_ldir = 0, p_rpwm = 0, p_rdir = 0, p_rst = 1;
  always @(negedge clk) begin
    chk("L_pwm", int'(L_pwm), int'(e_pwm[0]));
    chk("L_dir", int'(L_dir), int'(e_dir[0]));
    chk("L_busy", int'(L_busy), int'(e_busy[0]));
    chk("R_pwm", int'(R_pwm), int'(e_pwm[1]));
    chk("R_dir", int'(R_dir), int'(e_dir[1]));
    chk("R_busy", int'(R_busy), int'(e_busy[1]));
    chk("L_busy_pwm", int'(L_busy && L_pwm), 0);
    chk("R_busy_pwm", int'(R_busy && R_pwm), 0);
    if (!reset && !p_rst) begin
      chk("L_dir_while_pwm", int'((L_dir != p_ldir) && p_lpwm), 0);
      chk("R_dir_while_pwm", int'((R_dir != p_rdir) && p_rpwm), 0);
    end
    p_lpwm = L_pwm; p_ldir = L_dir; p_rpwm = R_pwm; p_rdir = R_dir;
    p_rst = reset;
  end

  // ---------------- stimulus helpers ----------------
  // inputs change 2 time units after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic goto_cnt(input int k);
    int n = 0;
    do begin step(1); n++; end while ((edges % P != k) && n < 2 * P);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      hi += int'(L_pwm);
      step(1);
    end
  endtask

  task automatic wait_lbusy(input int lim);
    int n = 0;
    while (!L_busy && n < lim) begin step(1); n++; end
    chk("lbusy_seen", int'(L_busy), 1);
  endtask

  initial begin
    int hi, n;
    #1 reset = 1;
    // reset/idle with requests active
    Len = 1; Ren = 1; duty = 8'd128;
    step(6);
    chk("rst_L_pwm", int'(L_pwm), 0);
    chk("rst_R_pwm", int'(R_pwm), 0);
    chk("rst_L_dir", int'(L_dir), 0);
    reset = 0;
    // duty_q stays 0 until the first wrap; first high cycle is edge 256
    step(255);
    chk("pre_wrap_lo", int'(L_pwm), 0);
    step(1);
    chk("wrap_hi", int'(L_pwm), 1);
    step(127);
    chk("hi127", int'(L_pwm), 1);
    step(1);
    chk("lo128", int'(L_pwm), 0);
    goto_cnt(0);
    count_high(P, hi);
    chk("d128_hi", hi, 128);

    // duty accuracy
    duty = 8'd64;
    goto_cnt(0);
    for (int p = 0; p < 4; p++) begin
      chk("d64_c0", int'(L_pwm), 1);
      count_high(P, hi);
      chk("d64_hi", hi, 64);
    end
    goto_cnt(63);
    chk("d64_c63", int'(L_pwm), 1);
    step(1);
    chk("d64_c64", int'(L_pwm), 0);
    duty = 8'd0;
    goto_cnt(0);
    count_high(P, hi);
    chk("d0_hi", hi, 0);
    duty = 8'd255;
    goto_cnt(0);
    count_high(P, hi);
    chk("d255_hi", hi, 256);

    // reversal dead-time
    Ldir = 1;
    wait_lbusy(10);
    n = 0;
    while (L_busy && n < 40) begin
      chk("dead_pwm0", int'(L_pwm), 0);
      chk("dead_dir_held", int'(L_dir), 0);
      chk("dead_R_pwm", int'(R_pwm), 1);
      n++;
      step(1);
    end
    chk("dead_len", n, 16);
    chk("rev_dir", int'(L_dir), 1);
    chk("rev_pwm", int'(L_pwm), 1);

    // enable drop and direction glitch during dead-time
    Ldir = 0;
    wait_lbusy(10);
    n = 0;
    while (L_busy && n < 40) begin
      n++;
      if (n == 5) begin Len = 0; Ldir = 1; end
      step(1);
    end
    chk("drop_dead_len", n, 16);
    chk("drop_dir", int'(L_dir), 1);
    chk("drop_pwm", int'(L_pwm), 0);
    step(10);
    chk("drop_stop_pwm", int'(L_pwm), 0);

    // mid-period duty change
    Len = 1;
    duty = 8'd200;
    goto_cnt(0);
    goto_cnt(50);
    duty = 8'd20;
    goto_cnt(199);
    chk("mid_c199", int'(L_pwm), 1);
    step(1);
    chk("mid_c200", int'(L_pwm), 0);
    goto_cnt(19);
    chk("mid_next_c19", int'(L_pwm), 1);
    step(1);
    chk("mid_next_c20", int'(L_pwm), 0);

    // reset in the middle of dead-time
    Ldir = 0;
    wait_lbusy(10);
    step(7);
    chk("pre_rst_busy", int'(L_busy), 1);
    reset = 1; Ldir = 1;
    #1;
    chk("rst_async_pwm", int'(L_pwm), 0);
    chk("rst_async_busy", int'(L_busy), 0);
    chk("rst_async_dir", int'(L_dir), 0);
    step(3);
    reset = 0;
    step(2);
    chk("rel_dir_e2", int'(L_dir), 0);
    step(1);
    chk("rel_dir_e3", int'(L_dir), 1);
    chk("rel_busy", int'(L_busy), 0);

    // random commands
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 39) == 0) Len  = ~Len;
      if ($urandom_range(0, 24) == 0) Ldir = ~Ldir;
      if ($urandom_range(0, 39) == 0) Ren  = ~Ren;
      if ($urandom_range(0, 24) == 0) Rdir = ~Rdir;
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 3))
          0: duty = 8'd0;
          1: duty = 8'd255;
          default: duty = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 4999) == 0) begin
        reset = 1;
        step($urandom_range(1, 3));
        reset = 0;
      end
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
